// File: rtl/ber_monitor.sv
// ber_monitor: finds tx->rx link latency, locks, and counts bit/word errors with saturating stats.
// Optional snapshot registers are enabled by defining BER_SNAPSHOT_EN.
module ber_monitor #(
   parameter int DATA_W      = 16,
   parameter int MAX_LAT     = 8,
   parameter int CNT_W       = 32,
   parameter int LOCK_WORDS  = 4,
   parameter int LOSS_THRESH = 4,
   parameter int LOSS_WORDS  = 4,
   localparam int LW = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic [DATA_W-1:0] tx_word,
   input  logic [DATA_W-1:0] rx_word,
   input  logic              clear,
   output logic              locked,
   output logic [LW-1:0]     lat_found,
   output logic [CNT_W-1:0]  bit_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  word_err_cnt,
   output logic              loss_sticky,
   output logic              sat
`ifdef BER_SNAPSHOT_EN
   ,
   input  logic              snap,
   output logic [CNT_W-1:0]  snap_bit_cnt,
   output logic [CNT_W-1:0]  snap_err_cnt,
   output logic [CNT_W-1:0]  snap_word_err_cnt,
   output logic              snap_valid
`endif
);
   localparam int EW = $clog2(DATA_W + 1);
   localparam int MW = $clog2(LOCK_WORDS + 1);
   localparam int BW = $clog2(LOSS_WORDS + 1);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t                          state;
   logic [MAX_LAT-2:0][DATA_W-1:0]  hist;
   logic [MAX_LAT-1:0][DATA_W-1:0]  tap;
   logic [DATA_W-1:0]               x;
   logic [EW-1:0]                   e;
   logic [MW-1:0]                   mcnt;
   logic [BW-1:0]                   bcnt, bcnt_n;
   logic [LW-1:0]                   d_inc;
   logic [CNT_W-1:0]                nb, ne, nw;
   logic                            upd, bad, lose, sat_n;

   // Saturating add: an overflowing sum clamps to all-ones.
   function automatic logic [CNT_W-1:0] sadd(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign tap   = {hist, tx_word};
   assign x     = rx_word ^ tap[lat_found];
   assign d_inc = (lat_found == LW'(MAX_LAT - 1)) ? '0 : lat_found + 1'b1;

   always_comb begin
      e = '0;
      for (int i = 0; i < DATA_W; i++) e = e + EW'(x[i]);
   end

   assign upd    = clk_enable && (state == LOCKED);
   assign nb     = upd ? sadd(bit_cnt, CNT_W'(DATA_W)) : bit_cnt;
   assign ne     = upd ? sadd(err_cnt, CNT_W'(e)) : err_cnt;
   assign nw     = upd ? sadd(word_err_cnt, CNT_W'(e != '0)) : word_err_cnt;
   assign sat_n  = sat | (upd & (&nb | &ne | &nw));
   assign bad    = int'(e) > LOSS_THRESH;
   assign bcnt_n = bad ? bcnt + 1'b1 : '0;
   assign lose   = upd && (bcnt_n == BW'(LOSS_WORDS));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= SEARCH;
         locked       <= 1'b0;
         lat_found    <= '0;
         hist         <= '0;
         mcnt         <= '0;
         bcnt         <= '0;
         bit_cnt      <= '0;
         err_cnt      <= '0;
         word_err_cnt <= '0;
         loss_sticky  <= 1'b0;
         sat          <= 1'b0;
      end else begin
         // clear wins over this word's contribution and acts even when disabled
         bit_cnt      <= clear ? '0 : nb;
         err_cnt      <= clear ? '0 : ne;
         word_err_cnt <= clear ? '0 : nw;
         sat          <= clear ? 1'b0 : sat_n;
         loss_sticky  <= clear ? 1'b0 : (loss_sticky | lose);
         if (clk_enable) begin
            hist <= tap[MAX_LAT-2:0];
            case (state)
               SEARCH:
                  if (e == '0) begin
                     state  <= (LOCK_WORDS == 1) ? LOCKED : VERIFY;
                     locked <= (LOCK_WORDS == 1);
                     mcnt   <= (LOCK_WORDS == 1) ? '0 : MW'(1);
                     bcnt   <= '0;
                  end else
                     lat_found <= d_inc;
               VERIFY:
                  if (e != '0) begin
                     state     <= SEARCH;
                     lat_found <= d_inc;
                     mcnt      <= '0;
                  end else if (mcnt + 1'b1 == MW'(LOCK_WORDS)) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                     mcnt   <= '0;
                     bcnt   <= '0;
                  end else
                     mcnt <= mcnt + 1'b1;
               default: begin
                  bcnt <= lose ? '0 : bcnt_n;
                  if (lose) begin
                     state     <= SEARCH;
                     locked    <= 1'b0;
                     lat_found <= d_inc;
                  end
               end
            endcase
         end
      end
   end

`ifdef BER_SNAPSHOT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_bit_cnt      <= '0;
         snap_err_cnt      <= '0;
         snap_word_err_cnt <= '0;
         snap_valid        <= 1'b0;
      end else begin
         snap_valid <= snap;
         if (snap) begin
            snap_bit_cnt      <= nb;
            snap_err_cnt      <= ne;
            snap_word_err_cnt <= nw;
         end
      end
   end
`endif
endmodule

// File: tb/tb_ber_monitor.sv
// tb_ber_monitor: drives a 32-bit and an 8-bit counter instance with shared stimulus
// and compares both against a word-level reference model of the latency search and statistics.
module tb_ber_monitor;
   localparam int MAX_LAT = 8;

   logic        clk = 1'b0;
   logic        reset, clk_enable, clear;
   logic [15:0] tx_word, rx_word;
   logic        locked_a, loss_a, sat_a, locked_b, loss_b, sat_b;
   logic [2:0]  lat_a, lat_b;
   logic [31:0] bit_a, err_a, werr_a;
   logic [7:0]  bit_b, err_b, werr_b;
`ifdef BER_SNAPSHOT_EN
   logic        snap = 1'b0;
   logic [31:0] sb_a, se_a, sw_a;
   logic [7:0]  sb_b, se_b, sw_b;
   logic        sv_a, sv_b;
`endif

   ber_monitor u_a (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .tx_word(tx_word), .rx_word(rx_word),
      .clear(clear), .locked(locked_a), .lat_found(lat_a), .bit_cnt(bit_a), .err_cnt(err_a),
      .word_err_cnt(werr_a), .loss_sticky(loss_a), .sat(sat_a)
`ifdef BER_SNAPSHOT_EN
      , .snap(snap), .snap_bit_cnt(sb_a), .snap_err_cnt(se_a), .snap_word_err_cnt(sw_a), .snap_valid(sv_a)
`endif
   );

   ber_monitor #(.CNT_W(8)) u_b (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .tx_word(tx_word), .rx_word(rx_word),
      .clear(clear), .locked(locked_b), .lat_found(lat_b), .bit_cnt(bit_b), .err_cnt(err_b),
      .word_err_cnt(werr_b), .loss_sticky(loss_b), .sat(sat_b)
`ifdef BER_SNAPSHOT_EN
      , .snap(snap), .snap_bit_cnt(sb_b), .snap_err_cnt(se_b), .snap_word_err_cnt(sw_b), .snap_valid(sv_b)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   logic [15:0] hist [MAX_LAT];
   logic [15:0] txh [$];
   int          d, run, bad;
   bit          mlocked, mloss;
   longint      tb, te, tw;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint clamp(input longint t, input int w);
      longint m = (64'd1 << w) - 1;
      return (t > m) ? m : t;
   endfunction

   function automatic bit msat(input int w);
      longint m = (64'd1 << w) - 1;
      return (tb >= m) || (te >= m) || (tw >= m);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "/locked32"}, locked_a, mlocked);
      chk({tag, "/lat32"},    lat_a,    d);
      chk({tag, "/bit32"},    bit_a,    clamp(tb, 32));
      chk({tag, "/err32"},    err_a,    clamp(te, 32));
      chk({tag, "/werr32"},   werr_a,   clamp(tw, 32));
      chk({tag, "/loss32"},   loss_a,   mloss);
      chk({tag, "/sat32"},    sat_a,    msat(32));
      chk({tag, "/locked8"},  locked_b, mlocked);
      chk({tag, "/lat8"},     lat_b,    d);
      chk({tag, "/bit8"},     bit_b,    clamp(tb, 8));
      chk({tag, "/err8"},     err_b,    clamp(te, 8));
      chk({tag, "/werr8"},    werr_b,   clamp(tw, 8));
      chk({tag, "/loss8"},    loss_b,   mloss);
      chk({tag, "/sat8"},     sat_b,    msat(8));
   endtask

   task automatic model_reset();
      foreach (hist[k]) hist[k] = '0;
      txh.delete();
      d = 0; run = 0; bad = 0; mlocked = 0; mloss = 0; tb = 0; te = 0; tw = 0;
   endtask

   // tx word sent L enabled words ago (zero before any history exists)
   function automatic logic [15:0] del(input logic [15:0] t, input int L);
      if (L == 0) return t;
      return (txh.size() >= L) ? txh[txh.size() - L] : 16'h0000;
   endfunction

   task automatic step(input string tag, input logic en, input logic clr, input logic [15:0] t, input logic [15:0] r);
      logic [15:0] refw;
      int e;
      clk_enable = en; clear = clr; tx_word = t; rx_word = r;
      @(posedge clk);
      if (en) begin
         refw = (d == 0) ? t : hist[d-1];
         e = $countones(r ^ refw);
         if (mlocked) begin
            tb += 16; te += e; tw += (e != 0);
            bad = (e > 4) ? bad + 1 : 0;
            if (bad == 4) begin mlocked = 0; mloss = 1; bad = 0; d = (d + 1) % MAX_LAT; end
         end else if (e == 0) begin
            run++;
            if (run == 4) begin mlocked = 1; run = 0; end
         end else begin
            run = 0; d = (d + 1) % MAX_LAT;
         end
         for (int k = MAX_LAT - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = t;
         txh.push_back(t);
      end
      if (clr) begin tb = 0; te = 0; tw = 0; mloss = 0; end
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1; clk_enable = 1'b0; clear = 1'b0; tx_word = '0; rx_word = '0;
      model_reset();
      #1;
      check_all("reset");
      @(posedge clk); @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      logic [15:0] t, r;
      longint e0, w0;
      do_reset();
      chk("reset_bit_zero", bit_a, 0);

      // zero latency lock and long error-free run
      for (int i = 0; i < 104; i++) begin
         t = 16'($urandom);
         step("lat0", 1'b1, 1'b0, t, t);
         if (i == 2) chk("not_locked_after_3", locked_a, 0);
         if (i == 3) chk("locked_after_4", locked_a, 1);
         if (i == 18) chk("bit8_pre_sat", bit_b, 240);
         if (i == 19) begin chk("bit8_sat_value", bit_b, 255); chk("sat8_set", sat_b, 1); end
      end
      chk("bit_1600", bit_a, 1600);
      chk("err_zero", err_a, 0);
      chk("lat0_found", lat_a, 0);

      // disabled cycles hold everything
      for (int i = 0; i < 10; i++) step("hold", 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      chk("hold_bit", bit_a, 1600);

      // latency 5 search
      do_reset();
      for (int i = 0; i < 20; i++) begin
         t = 16'($urandom);
         step("lat5", 1'b1, 1'b0, t, del(t, 5));
      end
      chk("lat5_locked", locked_a, 1);
      chk("lat5_found", lat_a, 5);
      chk("lat5_err", err_a, 0);

      // three flipped bits: counted but not bad
      e0 = te; w0 = tw;
      t = 16'($urandom);
      step("flip3", 1'b1, 1'b0, t, del(t, 5) ^ 16'h0700);
      chk("flip3_err", err_a, e0 + 3);
      chk("flip3_werr", werr_a, w0 + 1);
      chk("flip3_locked", locked_a, 1);
      for (int i = 0; i < 3; i++) begin
         t = 16'($urandom);
         step("clean", 1'b1, 1'b0, t, del(t, 5));
      end

      // four inverted words drop lock
      e0 = te; w0 = tw;
      for (int i = 0; i < 4; i++) begin
         t = 16'($urandom);
         step("invert", 1'b1, 1'b0, t, ~del(t, 5));
      end
      chk("loss_locked", locked_a, 0);
      chk("loss_sticky", loss_a, 1);
      chk("loss_lat", lat_a, 6);
      chk("loss_err", err_a, e0 + 64);
      chk("loss_werr", werr_a, w0 + 4);

      // clear while disabled
      step("clear", 1'b0, 1'b1, 16'($urandom), 16'($urandom));
      chk("clear_bit", bit_a, 0);
      chk("clear_loss", loss_a, 0);

      // randomized traffic at latency 2 with errors, gaps and clears
      for (int i = 0; i < 300; i++) begin
         t = 16'($urandom);
         r = del(t, 2);
         if ($urandom_range(7) == 0) r = ~r;
         else if ($urandom_range(5) == 0) r = r ^ (16'h1 << $urandom_range(15));
         step("random", ($urandom_range(3) != 0), ($urandom_range(49) == 0), t, r);
      end

      // relock, then reset asynchronously while locked
      for (int i = 0; i < 30; i++) begin
         t = 16'($urandom);
         step("relock", 1'b1, 1'b0, t, del(t, 2));
      end
      chk("prereset_locked", locked_a, 1);
      chk("prereset_lat", lat_a, 2);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_all("async_reset");
      chk("async_reset_locked", locked_a, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         t = 16'($urandom);
         step("after_reset", 1'b1, 1'b0, t, t);
         if (i == 2) chk("after_reset_unlocked", locked_a, 0);
      end
      chk("after_reset_locked", locked_a, 1);
      chk("after_reset_lat", lat_a, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ber_monitor.md
Name: ber_monitor

Overview:
- Parametrised bit-error-rate monitor for the convolutional-encoder / Viterbi-decoder link.
- Takes each transmitted word (noise-generator output fed to the encoder) and each received word (Viterbi decoder output).
- Finds the unknown link latency in words, locks onto it, then counts bit errors and word errors.
- Successor to the fixed 16-bit self-check: generalised in width, latency range and counter width, and adds lock/loss detection and saturating statistics.

Parameters:
- DATA_W, 16: width of tx_word and rx_word.
- MAX_LAT, 8: number of latencies searched, 0..MAX_LAT-1 words (MAX_LAT ≥ 2).
- CNT_W, 32: width of each statistics counter.
- LOCK_WORDS, 4: consecutive exact matches required to lock (≥ 1).
- LOSS_THRESH, 4: a word with more than this many bit errors is "bad".
- LOSS_WORDS, 4: consecutive bad words that drop lock (≥ 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_enable  in  1  word strobe; nothing advances when low.
- tx_word  in  DATA_W  transmitted word, valid when clk_enable=1.
- rx_word  in  DATA_W  received/decoded word, valid when clk_enable=1.
- clear  in  1  synchronous clear of statistics.
- locked  out  1  latency found and tracking.
- lat_found  out  max(1,clog2(MAX_LAT))  current trial/locked latency.
- bit_cnt  out  CNT_W  bits compared while locked.
- err_cnt  out  CNT_W  bit errors while locked.
- word_err_cnt  out  CNT_W  words with ≥1 bit error while locked.
- loss_sticky  out  1  lock was lost since last clear.
- sat  out  1  any counter has saturated since last clear.

Behaviour:
- Reset (async, active-high):
  - All outputs 0, FSM in SEARCH, trial latency d=0.
  - Delay line and match/bad-word counters cleared.
- Cycle gating:
  - Only enabled cycles (clk_enable=1) advance state.
  - With clk_enable=0, every register holds, including the delay line.
- Delay line:
  - tap[0] = tx_word (combinational). tap[k] = tx_word from k enabled cycles earlier, for k = 1..MAX_LAT-1.
  - Reference word ref = tap[d]. x = rx_word XOR ref. e = popcount(x).
- Latency: all outputs are registered and reflect an enabled cycle on the following clock edge.
- FSM:
  - SEARCH:
    - e=0: go to VERIFY, match count = 1.
    - Otherwise: d = d+1, wrapping MAX_LAT-1 → 0.
    - If LOCK_WORDS=1, e=0 goes straight to LOCKED.
  - VERIFY:
    - e=0: match count increments; on reaching LOCK_WORDS, go to LOCKED.
    - e≠0: go to SEARCH, d = d+1 (with wrap), match count = 0.
  - LOCKED:
    - locked=1.
    - Every enabled word: bit_cnt += DATA_W, err_cnt += e, word_err_cnt += (e≠0).
    - e > LOSS_THRESH increments the bad count; any other word resets it to 0.
    - When the bad count reaches LOSS_WORDS: go to SEARCH, loss_sticky=1, locked=0, d=d+1 (with wrap).
- Counting boundaries:
  - The word completing VERIFY is not counted; counting starts with the next word.
  - The words that cause loss of lock are counted.
- lat_found always shows d (trial value in SEARCH/VERIFY, locked value in LOCKED).
- Search correctness requires non-periodic tx data within MAX_LAT words. Constant data locks at the first trial latency; this is accepted behaviour.
- Saturation:
  - A counter at all-ones holds its value and sets sat.
  - If an addition would overflow, the counter clamps to all-ones and sets sat.
  - sat is sticky.
- clear:
  - Zeroes bit_cnt, err_cnt, word_err_cnt, loss_sticky and sat.
  - Does not affect FSM, d, delay line or lock.
  - clear wins over a same-cycle update: that word's contribution is dropped.
  - clear acts regardless of clk_enable.
- Reset mid-operation returns everything to reset values immediately, including in LOCKED.

Optional Feature:
- Macro: BER_SNAPSHOT_EN.
- With the macro defined:
  - Adds input snap (1 bit) and outputs snap_bit_cnt, snap_err_cnt, snap_word_err_cnt (CNT_W each) and snap_valid (1 bit).
  - snap=1 copies the three counters, including the current cycle's update, into the snapshot registers on that edge. snap_valid pulses 1 for one cycle after the copy.
  - snap with clear in the same cycle: the snapshot captures the pre-clear values plus this word's update.
  - Snapshot registers reset to 0 and are not affected by clear.
- Without the macro: the snapshot ports and registers are absent.

Test Plan:
- Zero latency: rx=tx, distinct values, LOCK_WORDS=4 → locked=1 after the 4th matching word, lat_found=0. After 100 further words: bit_cnt=1600, err_cnt=0.
- Latency 5: rx = tx delayed 5 enabled words → search steps d=0..5, locked=1, lat_found=5, err_cnt=0.
- While locked, flip 3 bits of one rx word → err_cnt +3, word_err_cnt +1, bad count unaffected (3 ≤ 4), locked stays 1.
- While locked, rx=~tx for 4 words → err_cnt +64, word_err_cnt +4, locked=0, loss_sticky=1, lat_found advanced by 1. Then a clear pulse → counters and loss_sticky = 0.
- CNT_W=8, locked, error-free → after 16 words bit_cnt=255 and sat=1. With clk_enable=0 for 10 cycles mid-run, all outputs are unchanged.
- Reset asserted while locked with nonzero counters → all outputs 0 immediately, FSM in SEARCH with d=0; relock occurs after LOCK_WORDS matching words.
